vd_avg_filter: RTL and testbench
================================

Name: vd_avg_filter

Overview:
Moving-average stage between the voltage-sample source and the PID error stage.
- Keeps a window of the last 2^DEPTH_LOG2 voltage samples.
- On the sequencer's shift_avg strobe, shifts in a new sample.
- On calc_avg, sums the window one tap per clock, divides by the depth, and returns the result with a one-cycle avg_done pulse.

Parameters:
DATA_W, 12, width of each voltage sample and of the averaged result
DEPTH_LOG2, 3, log2 of the window depth (default depth 8)

Ports:
clk  input  1  system clock; all logic on rising edge
n_rst  input  1  reset, synchronous, active-low
shift_avg  input  1  one-cycle strobe; shift vd_in into the window
calc_avg  input  1  one-cycle strobe; start averaging the current window
vd_in  input  DATA_W  current voltage sample, sampled when shift_avg is accepted
avg_out  output  DATA_W  window average, registered
avg_done  output  1  one-cycle pulse; avg_out updated this cycle
busy  output  1  high while a calculation is in progress (state != IDLE)
window_full  output  1  sticky; high once DEPTH samples have been shifted in since reset

Behaviour:
Reset:
- Any clock edge with n_rst=0 clears every tap, the accumulator, the tap index, the fill counter and avg_out to 0.
- State returns to IDLE.
- avg_done, busy and window_full are all 0.
- Reset overrides any calculation in progress; no avg_done pulse is emitted for an aborted calculation.

Window:
- DEPTH = 2^DEPTH_LOG2 taps, tap[0] is the newest sample.
- shift_avg is accepted only in IDLE: tap[0] <= vd_in, and tap[i] <= tap[i-1] for i = 1..DEPTH-1.
- shift_avg in SUM or DONE is ignored; the sample is dropped and the taps are unchanged.
- A saturating fill counter increments on each accepted shift.
- window_full = 1 once the counter reaches DEPTH, and stays 1 until reset.

State machine (IDLE, SUM, DONE):
- IDLE:
  - calc_avg=1: clear the accumulator, set idx=0, go to SUM.
  - shift_avg and calc_avg both high in the same cycle: the shift is performed on that edge, so the sum uses the updated window, including the new vd_in.
- SUM:
  - Each cycle, acc <= acc + tap[idx] and idx <= idx + 1.
  - When idx = DEPTH-1: avg_out <= (acc + tap[DEPTH-1]) >> DEPTH_LOG2, then go to DONE.
  - calc_avg and shift_avg are ignored.
- DONE:
  - avg_done = 1 for exactly this cycle, then go to IDLE.
  - calc_avg in DONE is ignored.

Outputs and timing:
- busy = 1 in SUM and DONE.
- avg_done is decoded from state == DONE.
- Latency: with calc_avg sampled at edge k, SUM occupies cycles k+1 .. k+DEPTH and avg_done is high in cycle k+DEPTH+1.
- Back-to-back calculations: the earliest a new calc_avg can be accepted is the cycle after DONE.
- avg_out holds its value between completions.

Arithmetic:
- Accumulator width is DATA_W + DEPTH_LOG2, unsigned; it cannot overflow.
- Division is a truncating right shift (floor); no rounding.
- Before window_full, empty taps contribute 0. The average is still divided by DEPTH, not by the fill count.

Test Plan:
- Reset, then 8 shifts of vd_in=100, then calc_avg -> busy high for 9 cycles; avg_done pulses exactly 9 cycles after calc_avg with avg_out=100; window_full=1.
- Shift samples 0,1,...,7, then calc_avg -> avg_out=3 (sum 28>>3, truncated); a following 8 shifts of 7 then calc_avg -> avg_out=7.
- 8 shifts of 4095, then calc_avg -> avg_out=4095; no overflow (accumulator peak 32760).
- After reset, 3 shifts of 800, then calc_avg -> avg_out=300 (2400>>3); window_full=0.
- Window of 8×200; in one cycle assert shift_avg with vd_in=1000 together with calc_avg -> avg_out=300 ((1400+1000)>>3). Then pulse shift_avg during SUM -> ignored; the next calc gives 300 again.
- Assert n_rst=0 during the 4th SUM cycle -> next edge: busy=0, no avg_done pulse, avg_out=0, window_full=0, all taps 0; a subsequent calc_avg yields avg_out=0.

Source files
------------

// File: rtl/vd_avg_filter_if.sv
// Sample/strobe bundle between the sequencer and the moving-average stage.
// Master drives the strobes and the sample; slave returns the averaged result and status.
interface vd_avg_filter_if #(
  parameter int DATA_W = 12
);
  logic              shift_avg;
  logic              calc_avg;
  logic [DATA_W-1:0] vd_in;
  logic [DATA_W-1:0] avg_out;
  logic              avg_done;
  logic              busy;
  logic              window_full;

  modport master (
    output shift_avg, calc_avg, vd_in,
    input  avg_out, avg_done, busy, window_full
  );

  modport slave (
    input  shift_avg, calc_avg, vd_in,
    output avg_out, avg_done, busy, window_full
  );
endinterface

// File: rtl/vd_avg_filter.sv
// Moving-average filter over the last 2^DEPTH_LOG2 voltage samples.
// Summation is serial, one tap per clock; the result is floor(sum / DEPTH).

// One window tap: loads its neighbour's value on an accepted shift.
module vd_avg_tap #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);
  logic [DATA_W-1:0] tap_q;

  always_ff @(posedge clk) begin
    if (!n_rst)    tap_q <= '0;
    else if (en_i) tap_q <= d_i;
  end

  assign q_o = tap_q;
endmodule

module vd_avg_filter #(
  parameter int DATA_W     = 12,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic           clk,
  input  logic           n_rst,
  vd_avg_filter_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ACC_W = DATA_W + DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] IDX_LAST = DEPTH_LOG2'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DEPTH-1:0][DATA_W-1:0] tap_q;
  logic [ACC_W-1:0]             acc_q, acc_d;
  logic [DEPTH_LOG2-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]            avg_q, avg_d;
  logic [DEPTH_LOG2:0]          fill_q, fill_d;
  logic [ACC_W-1:0]             sum;
  logic                         shift_acc;

  // Shifts are only honoured while idle so the window is frozen during a sum.
  assign shift_acc = (state_q == IDLE) && bus.shift_avg;

  // Tap 0 takes the new sample; every other tap takes its younger neighbour.
  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    logic [DATA_W-1:0] d;
    if (i == 0) begin : g_head
      assign d = bus.vd_in;
    end else begin : g_body
      assign d = tap_q[i-1];
    end
    vd_avg_tap #(.DATA_W(DATA_W)) u_tap (
      .clk  (clk),
      .n_rst(n_rst),
      .en_i (shift_acc),
      .d_i  (d),
      .q_o  (tap_q[i])
    );
  end

  assign sum = acc_q + ACC_W'(tap_q[idx_q]);

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    avg_d   = avg_q;
    fill_d  = fill_q;
    // MSB of the fill counter doubles as the saturation flag.
    if (shift_acc && !fill_q[DEPTH_LOG2]) fill_d = fill_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.calc_avg) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = SUM;
        end
      end
      SUM: begin
        acc_d = sum;
        idx_d = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          avg_d   = DATA_W'(sum >> DEPTH_LOG2);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc_q  <= '0;
      idx_q  <= '0;
      avg_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      avg_q  <= avg_d;
      fill_q <= fill_d;
    end
  end

  assign bus.avg_out     = avg_q;
  assign bus.avg_done    = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.window_full = fill_q[DEPTH_LOG2];
endmodule

// File: tb/tb_vd_avg_filter.sv
// Scoreboard bench: each calc pushes its expected average; a negedge monitor
// pops and compares whenever avg_done is seen.
module tb_vd_avg_filter;
  localparam int DATA_W = 12;

  logic clk = 1'b0;
  logic n_rst;
  int   total  = 0;
  int   passed = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  vd_avg_filter_if #(.DATA_W(DATA_W)) bus ();

  vd_avg_filter #(.DATA_W(DATA_W), .DEPTH_LOG2(3)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.avg_done) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got avg_out %0d expected no pulse", bus.avg_out);
      end else begin
        check("avg_out", int'(bus.avg_out), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    tick();
    check("rst_avg_out", int'(bus.avg_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.avg_done), 0);
    check("rst_full", int'(bus.window_full), 0);
    n_rst = 1'b1;
  endtask

  task automatic shift(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.shift_avg = 1'b1;
      bus.vd_in     = DATA_W'(v);
      tick();
    end
    bus.shift_avg = 1'b0;
  endtask

  // Issue calc_avg (optionally with a shift in the same cycle), then measure
  // latency and busy width; optionally pulse a stray shift mid-sum.
  task automatic calc(input int exp, input bit with_shift, input int sv, input bit mid_shift);
    int lat, busy_n;
    bus.calc_avg = 1'b1;
    if (with_shift) begin
      bus.shift_avg = 1'b1;
      bus.vd_in     = DATA_W'(sv);
    end
    exp_q.push_back(DATA_W'(exp));
    tick();
    bus.calc_avg  = 1'b0;
    bus.shift_avg = 1'b0;
    lat    = 1;
    busy_n = int'(bus.busy);
    while (!bus.avg_done && lat < 20) begin
      if (mid_shift && lat == 3) begin
        bus.shift_avg = 1'b1;
        bus.vd_in     = DATA_W'(4000);
      end
      tick();
      bus.shift_avg = 1'b0;
      lat++;
      busy_n += int'(bus.busy);
    end
    check("latency", lat, 9);
    check("busy_cycles", busy_n, 9);
    tick();
    check("busy_after", int'(bus.busy), 0);
    check("done_after", int'(bus.avg_done), 0);
  endtask

  initial begin
    bus.shift_avg = 1'b0;
    bus.calc_avg  = 1'b0;
    bus.vd_in     = '0;
    n_rst         = 1'b0;
    do_reset();

    // Uniform window
    shift(100, 8);
    check("full_8", int'(bus.window_full), 1);
    calc(100, 1'b0, 0, 1'b0);
    check("hold_avg", int'(bus.avg_out), 100);

    // Ramp 0..7 truncates to 3, then all-7 window
    for (int i = 0; i < 8; i++) shift(i, 1);
    calc(3, 1'b0, 0, 1'b0);
    shift(7, 8);
    calc(7, 1'b0, 0, 1'b0);

    // Full-scale window
    shift(4095, 8);
    calc(4095, 1'b0, 0, 1'b0);

    // Partial fill still divides by depth
    do_reset();
    shift(800, 3);
    check("full_3", int'(bus.window_full), 0);
    calc(300, 1'b0, 0, 1'b0);
    check("full_3_after", int'(bus.window_full), 0);

    // Same-cycle shift+calc, then a shift during SUM is dropped
    shift(200, 8);
    calc(300, 1'b1, 1000, 1'b1);
    calc(300, 1'b0, 0, 1'b0);

    // Reset during the 4th SUM cycle aborts without a pulse
    bus.calc_avg = 1'b1;
    tick();
    bus.calc_avg = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_pre", int'(bus.busy), 1);
    n_rst = 1'b0;
    tick();
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.avg_done), 0);
    check("abort_avg", int'(bus.avg_out), 0);
    check("abort_full", int'(bus.window_full), 0);
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    calc(0, 1'b0, 0, 1'b0);

    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
